// File: rtl/sparc_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sparc_rf_pkg
// Description : Shared constants and helpers for the integer register file
//               write path (geometry, %g0 address, round-robin increment).
// Revision    : 1.0 - initial release
// ============================================================================
package sparc_rf_pkg;

    localparam int             RF_AW   = 5;
    localparam int             RF_DW   = 32;
    localparam int             RF_NREG = 32;

    // %g0 reads as zero, so writes to it are dropped at the enable decode
    localparam logic [RF_AW-1:0] G0_ADDR = 5'd0;

    // Modulo-n increment of a round-robin pointer
    function automatic int unsigned onehot_ptr_next(input int unsigned ptr,
                                                    input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage : sparc_rf_pkg
`default_nettype wire

// File: rtl/rf_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module      : rf_onehot_dec
// Description : Combinational register-address to one-hot write-enable
//               decoder with a global enable.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_onehot_dec
    import sparc_rf_pkg::*;
#(
    parameter int AW = RF_AW
) (
    input  logic               i_en,
    input  logic [AW-1:0]      i_addr,
    output logic [RF_NREG-1:0] o_onehot
);

    // One compare per register; all bits low when disabled
    for (genvar i = 0; i < RF_NREG; i++) begin : g_dec
        assign o_onehot[i] = i_en && (i_addr == AW'(i));
    end

endmodule : rf_onehot_dec
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Round-robin arbiter for the single register file write port.
//               One requester is granted per cycle (combinational Gnt); its
//               address/data are registered and decoded into a one-hot
//               write enable the following cycle. %g0 writes are granted
//               but produce no enable.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter
    import sparc_rf_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic [NREQ-1:0]      Req,
    input  logic [NREQ*AW-1:0]   ReqAddr,
    input  logic [NREQ*DW-1:0]   ReqData,
    input  logic                 Hold,
    output logic [NREQ-1:0]      Gnt,
    output logic [RF_NREG-1:0]   WrEn,
    output logic [AW-1:0]        WrAddr,
    output logic [DW-1:0]        WrData,
    output logic                 Busy
);

    localparam int                 c_ptr_w = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [c_ptr_w:0]   c_nreq  = (c_ptr_w + 1)'(NREQ);

    logic [c_ptr_w-1:0]   r_ptr;
    logic [2*NREQ-1:0]    w_req_dbl;
    logic [NREQ-1:0]      w_req_rot;
    logic                 w_found;
    logic [c_ptr_w-1:0]   w_rot_idx;
    logic [c_ptr_w:0]     w_sum;
    logic [c_ptr_w-1:0]   w_winner;
    logic                 w_valid;
    logic [NREQ-1:0]      w_gnt;
    logic [AW-1:0]        w_sel_addr;
    logic [DW-1:0]        w_sel_data;
    logic                 w_dec_en;
    logic [RF_NREG-1:0]   w_dec;

    // Rotate requests so the pointer's requester sits at bit 0
    assign w_req_dbl = {Req, Req};
    assign w_req_rot = w_req_dbl[r_ptr +: NREQ];

    // First set bit of the rotated request vector
    always_comb begin
        w_found   = 1'b0;
        w_rot_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_req_rot[k]) begin
                w_found   = 1'b1;
                w_rot_idx = c_ptr_w'(k);
            end
        end
    end

    // Rotate the found index back into requester numbering
    assign w_sum    = {1'b0, r_ptr} + {1'b0, w_rot_idx};
    assign w_winner = (w_sum >= c_nreq) ? c_ptr_w'(w_sum - c_nreq) : c_ptr_w'(w_sum);

    // Hold and reset both block the grant within the current cycle
    assign w_valid = w_found && !Hold && Reset_n;

    // One-hot grant of the winner
    always_comb begin
        w_gnt = '0;
        if (w_valid) begin
            w_gnt[w_winner] = 1'b1;
        end
    end
    assign Gnt = w_gnt;

    assign w_sel_addr = ReqAddr[w_winner*AW +: AW];
    assign w_sel_data = ReqData[w_winner*DW +: DW];

    // %g0 still wins the port but never raises an enable
    assign w_dec_en = w_valid && (w_sel_addr != AW'(G0_ADDR));

    rf_onehot_dec #(
        .AW (AW)
    ) u_dec (
        .i_en     (w_dec_en),
        .i_addr   (w_sel_addr),
        .o_onehot (w_dec)
    );

    // Output registers and round-robin pointer update on each grant
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ptr  <= '0;
            WrEn   <= '0;
            WrAddr <= '0;
            WrData <= '0;
            Busy   <= 1'b0;
        end else begin
            WrEn <= w_dec;
            Busy <= |w_dec;
            if (w_valid) begin
                WrAddr <= w_sel_addr;
                WrData <= w_sel_data;
                r_ptr  <= c_ptr_w'(onehot_ptr_next(32'(w_winner), NREQ));
            end
        end
    end

endmodule : rf_write_arbiter
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Directed self-checking bench for rf_write_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    logic          Clk;
    logic          Reset_n;
    logic [3:0]    Req;
    logic [19:0]   ReqAddr;
    logic [127:0]  ReqData;
    logic          Hold;
    logic [3:0]    Gnt;
    logic [31:0]   WrEn;
    logic [4:0]    WrAddr;
    logic [31:0]   WrData;
    logic          Busy;

    logic [4:0]    a [4];
    logic [31:0]   d [4];

    int n_checks = 0;
    int n_pass   = 0;

    assign ReqAddr = {a[3], a[2], a[1], a[0]};
    assign ReqData = {d[3], d[2], d[1], d[0]};

    rf_write_arbiter #(
        .NREQ (4),
        .AW   (5),
        .DW   (32)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Req     (Req),
        .ReqAddr (ReqAddr),
        .ReqData (ReqData),
        .Hold    (Hold),
        .Gnt     (Gnt),
        .WrEn    (WrEn),
        .WrAddr  (WrAddr),
        .WrData  (WrData),
        .Busy    (Busy)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset_n = 1'b0;
        Req     = 4'b0000;
        Hold    = 1'b0;
        a[0] = 5'd0;  a[1] = 5'd7;  a[2] = 5'd8;  a[3] = 5'd12;
        d[0] = 32'h0; d[1] = 32'hDEADBEEF; d[2] = 32'hCAFE0008; d[3] = 32'hA5A50003;

        // Power-on reset state
        #12;
        chk("por_wren",   WrEn,   32'h0);
        chk("por_wraddr", 32'(WrAddr), 32'h0);
        chk("por_wrdata", WrData, 32'h0);
        chk("por_busy",   32'(Busy), 32'h0);
        chk("por_ptr",    32'(dut.r_ptr), 32'h0);
        Reset_n = 1'b1;
        tick();

        // Single requester 1 -> %r7
        Req = 4'b0010;
        #1 chk("single_gnt", 32'(Gnt), 32'h2);
        tick();
        Req = 4'b0000;
        chk("single_wren",   WrEn,   32'h0000_0080);
        chk("single_wraddr", 32'(WrAddr), 32'd7);
        chk("single_wrdata", WrData, 32'hDEADBEEF);
        chk("single_busy",   32'(Busy), 32'h1);
        chk("single_ptr",    32'(dut.r_ptr), 32'd2);
        tick();
        chk("single_wren_drop", WrEn, 32'h0);
        chk("single_busy_drop", 32'(Busy), 32'h0);
        chk("single_addr_hold", 32'(WrAddr), 32'd7);

        // Hold blocks requester 3 for three cycles
        Req  = 4'b1000;
        Hold = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 chk("hold_gnt", 32'(Gnt), 32'h0);
            tick();
            chk("hold_wren", WrEn, 32'h0);
        end
        Hold = 1'b0;
        #1 chk("unhold_gnt", 32'(Gnt), 32'h8);
        tick();
        Req = 4'b0000;
        chk("unhold_wren",   WrEn, 32'h0000_1000);
        chk("unhold_wraddr", 32'(WrAddr), 32'd12);
        chk("unhold_ptr",    32'(dut.r_ptr), 32'd0);

        // %g0 write: granted, no enable, pointer advances
        d[0] = 32'h1234;
        Req  = 4'b0001;
        #1 chk("g0_gnt", 32'(Gnt), 32'h1);
        tick();
        Req = 4'b0000;
        chk("g0_wren",   WrEn, 32'h0);
        chk("g0_busy",   32'(Busy), 32'h0);
        chk("g0_wraddr", 32'(WrAddr), 32'h0);
        chk("g0_wrdata", WrData, 32'h1234);
        chk("g0_ptr",    32'(dut.r_ptr), 32'd1);

        // Move pointer to 3 via requester 2
        a[0] = 5'd3;
        Req  = 4'b0100;
        #1 chk("p3_gnt", 32'(Gnt), 32'h4);
        tick();
        Req = 4'b0000;
        chk("p3_wren", WrEn, 32'h0000_0100);
        chk("p3_ptr",  32'(dut.r_ptr), 32'd3);

        // Wrap: Ptr=3 with requesters 3 and 0 pending
        Req = 4'b1001;
        #1 chk("wrap_gnt3", 32'(Gnt), 32'h8);
        tick();
        Req = 4'b0001;
        chk("wrap_wren3", WrEn, 32'h0000_1000);
        chk("wrap_ptr0",  32'(dut.r_ptr), 32'd0);
        #1 chk("wrap_gnt0", 32'(Gnt), 32'h1);
        tick();
        Req = 4'b0000;
        chk("wrap_wren0", WrEn, 32'h0000_0008);
        chk("wrap_ptr1",  32'(dut.r_ptr), 32'd1);

        // Issued write survives Hold, then reset lands mid-write
        Req = 4'b0100;
        #1 chk("rst_pre_gnt", 32'(Gnt), 32'h4);
        tick();
        Hold = 1'b1;
        #1;
        chk("hold_keeps_wren", WrEn, 32'h0000_0100);
        chk("hold_gnt_zero",   32'(Gnt), 32'h0);
        Hold = 1'b0;
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_wren",   WrEn, 32'h0);
        chk("rst_wraddr", 32'(WrAddr), 32'h0);
        chk("rst_wrdata", WrData, 32'h0);
        chk("rst_busy",   32'(Busy), 32'h0);
        chk("rst_gnt",    32'(Gnt), 32'h0);
        chk("rst_ptr",    32'(dut.r_ptr), 32'h0);
        Req     = 4'b0000;
        Reset_n = 1'b1;
        tick();

        // All four requesting continuously: 0,1,2,3,0
        Req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1 chk("rr_gnt", 32'(Gnt), 32'h1 << (k % 4));
            tick();
            chk("rr_wren",   WrEn,   32'h1 << a[k % 4]);
            chk("rr_wrdata", WrData, d[k % 4]);
        end
        Req = 4'b0000;
        chk("rr_ptr", 32'(dut.r_ptr), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_rf_write_arbiter
`default_nettype wire
